// File: rtl/nlms_frame_sequencer.sv
// nlms_frame_sequencer
// Per-sample frame controller for the 32-tap NLMS datapath. A Moore FSM steps
// through FILTER (MAC sweep), LATCH (error capture), DIV (normaliser) and
// UPDATE (tap-by-tap weight write), then pulses frame_done. It also keeps a
// completed-frame count and two sticky error flags. Every output comes from a
// register or is decoded from the state register, so no input reaches an
// output combinationally.

module nlms_frame_sequencer #(
    parameter int TAPS        = 32,
    parameter int FILT_CYCLES = 36,
    parameter int DIV_TIMEOUT = 63,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sample_valid,
    input  logic              adapt_en,
    input  logic              div_done,
    input  logic              clr_err,
    output logic              sample_ready,
    output logic              adap_filter_state,
    output logic              div_state,
    output logic              upd_en,
    output logic [ADDR_W-1:0] upd_addr,
    output logic              frame_done,
    output logic [15:0]       sample_cnt,
    output logic              err_overrun,
    output logic              err_timeout
);

    // One extra bit over the tap address so that the FILTER and DIV dwell
    // counts, which exceed TAPS, fit in the same counter.
    localparam int CNT_W = ADDR_W + 1;

    // Terminal counter values: each state is left in the cycle where the
    // counter, cleared on entry, reaches its dwell length minus one.
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] UPD_LAST  = CNT_W'(TAPS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILTER = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_DIV    = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_adapt_q;
    logic [15:0]      r_sample_cnt;
    logic             r_err_overrun;
    logic             r_err_timeout;

    logic             w_accept;
    logic             w_overrun_set;
    logic             w_timeout_set;

    // A sample is only taken in IDLE; anywhere else (DONE included) it is
    // dropped and flagged, without disturbing the frame in progress.
    assign w_accept      = (r_state == S_IDLE) && sample_valid;
    assign w_overrun_set = (r_state != S_IDLE) && sample_valid;

    // A div_done arriving in the final DIV cycle still counts as an answer,
    // so the timeout only fires when that last cycle passes silently.
    assign w_timeout_set = (r_state == S_DIV) && !div_done && (r_cnt == DIV_LAST);

    // Next-state decode for the frame sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (sample_valid) begin
                    w_next = S_FILTER;
                end
            end
            S_FILTER: begin
                if (r_cnt == FILT_LAST) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                w_next = r_adapt_q ? S_DIV : S_DONE;
            end
            S_DIV: begin
                if (div_done) begin
                    w_next = S_UPDATE;
                end else if (r_cnt == DIV_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_UPDATE: begin
                if (r_cnt == UPD_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register plus the shared dwell counter, cleared on every state
    // change so each state counts from zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Capture the frame mode at acceptance so adapt_en may change mid-frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_adapt_q <= 1'b0;
        end else if (w_accept) begin
            r_adapt_q <= adapt_en;
        end
    end

    // Completed-frame counter; it steps as DONE is left and wraps naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sample_cnt <= '0;
        end else if (r_state == S_DONE) begin
            r_sample_cnt <= r_sample_cnt + 16'd1;
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err survives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_overrun_set) begin
                r_err_overrun <= 1'b1;
            end else if (clr_err) begin
                r_err_overrun <= 1'b0;
            end
            if (w_timeout_set) begin
                r_err_timeout <= 1'b1;
            end else if (clr_err) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

    // Strobes are pure state decodes; the weight address is the UPDATE dwell
    // count and reads zero in every other state.
    assign sample_ready      = (r_state == S_IDLE);
    assign adap_filter_state = (r_state == S_FILTER);
    assign div_state         = (r_state == S_DIV);
    assign upd_en            = (r_state == S_UPDATE);
    assign upd_addr          = (r_state == S_UPDATE) ? r_cnt[ADDR_W-1:0] : '0;
    assign frame_done        = (r_state == S_DONE);
    assign sample_cnt        = r_sample_cnt;
    assign err_overrun       = r_err_overrun;
    assign err_timeout       = r_err_timeout;

endmodule

// File: tb/tb_nlms_frame_sequencer.sv
// Testbench for nlms_frame_sequencer: directed frame scenarios with literal
// timing expectations, plus randomized traffic checked every cycle against a
// timeline model of the frame.

module tb_nlms_frame_sequencer;

    localparam int TAPS = 32;
    localparam int FC   = 36;
    localparam int DT   = 63;
    localparam int AW   = 6;

    logic          clk          = 1'b0;
    logic          rstn         = 1'b1;
    logic          sample_valid = 1'b0;
    logic          adapt_en     = 1'b0;
    logic          div_done     = 1'b0;
    logic          clr_err      = 1'b0;
    logic          sample_ready;
    logic          adap_filter_state;
    logic          div_state;
    logic          upd_en;
    logic [AW-1:0] upd_addr;
    logic          frame_done;
    logic [15:0]   sample_cnt;
    logic          err_overrun;
    logic          err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    nlms_frame_sequencer #(
        .TAPS        (TAPS),
        .FILT_CYCLES (FC),
        .DIV_TIMEOUT (DT),
        .ADDR_W      (AW)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .sample_valid      (sample_valid),
        .adapt_en          (adapt_en),
        .div_done          (div_done),
        .clr_err           (clr_err),
        .sample_ready      (sample_ready),
        .adap_filter_state (adap_filter_state),
        .div_state         (div_state),
        .upd_en            (upd_en),
        .upd_addr          (upd_addr),
        .frame_done        (frame_done),
        .sample_cnt        (sample_cnt),
        .err_overrun       (err_overrun),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline reference model ----------------
    // A frame accepted in cycle T is described by T, its mode and, once the
    // divider answers, the answering cycle. Every expected output is a
    // function of the offset of the current cycle from those marks.
    int          m_c         = 0;
    bit          model_on    = 1'b0;
    bit          m_active    = 1'b0;
    int          m_T         = 0;
    bit          m_adapt     = 1'b0;
    bit          m_resp      = 1'b0;
    int          m_div_end   = 0;
    logic [15:0] m_cnt       = 16'd0;
    bit          m_ovr       = 1'b0;
    bit          m_to        = 1'b0;
    int          preload_req = 0;
    int          preload_seen = 0;

    always @(negedge clk) begin : cmp
        int off;
        int e_addr;
        bit e_ready;
        bit e_filt;
        bit e_div;
        bit e_upd;
        bit e_done;
        bit s_ovr;
        bit s_to;
        if (preload_seen != preload_req) begin
            m_cnt        = 16'hFFFF;
            preload_seen = preload_req;
        end
        if (!rstn) begin
            model_on = 1'b1;
            m_active = 1'b0;
            m_resp   = 1'b0;
            m_cnt    = 16'd0;
            m_ovr    = 1'b0;
            m_to     = 1'b0;
        end
        if (model_on) begin
            off     = m_c - m_T;
            e_ready = !m_active;
            e_filt  = m_active && off >= 1 && off <= FC;
            e_div   = m_active && m_adapt && off >= FC + 2 &&
                      (m_resp ? (m_c <= m_div_end) : (off <= FC + 1 + DT));
            e_upd   = m_active && m_resp && m_c > m_div_end && m_c <= m_div_end + TAPS;
            e_addr  = e_upd ? (m_c - m_div_end - 1) : 0;
            if (!m_active)
                e_done = 1'b0;
            else if (!m_adapt)
                e_done = (off == FC + 2);
            else if (m_resp)
                e_done = (m_c == m_div_end + TAPS + 1);
            else
                e_done = (off == FC + 2 + DT);

            chk("sample_ready", int'(sample_ready), int'(e_ready));
            chk("adap_filter_state", int'(adap_filter_state), int'(e_filt));
            chk("div_state", int'(div_state), int'(e_div));
            chk("upd_en", int'(upd_en), int'(e_upd));
            chk("upd_addr", int'(upd_addr), e_addr);
            chk("frame_done", int'(frame_done), int'(e_done));
            chk("sample_cnt", int'(sample_cnt), int'(m_cnt));
            chk("err_overrun", int'(err_overrun), int'(m_ovr));
            chk("err_timeout", int'(err_timeout), int'(m_to));

            if (rstn) begin
                s_ovr = sample_valid && !e_ready;
                s_to  = e_div && !div_done && (off == FC + 1 + DT);
                if (e_ready && sample_valid) begin
                    m_active = 1'b1;
                    m_T      = m_c;
                    m_adapt  = adapt_en;
                    m_resp   = 1'b0;
                end
                if (e_div && div_done) begin
                    m_resp    = 1'b1;
                    m_div_end = m_c;
                end
                if (e_done) begin
                    m_cnt    = m_cnt + 16'd1;
                    m_active = 1'b0;
                end
                if (s_ovr)        m_ovr = 1'b1;
                else if (clr_err) m_ovr = 1'b0;
                if (s_to)         m_to = 1'b1;
                else if (clr_err) m_to = 1'b0;
            end
        end
        m_c++;
    end

    // ---------------- directed frame runner ----------------
    int          f_first, f_last, d_first, d_last, d_n, u_first, u_n;
    int          done_t, ovr_first, to_first;
    bit          addr_ok;
    logic [15:0] cnt_end;
    logic        rdy_end;

    // Drives one frame starting in the current cycle (T = 0) and records
    // when each strobe was seen; -1 offsets disable the optional events.
    task automatic frame(input int len, input bit ae, input int dd_at,
                         input int sv2_at, input int dd2_at);
        f_first = -1; f_last = -1; d_first = -1; d_last = -1; d_n = 0;
        u_first = -1; u_n = 0; done_t = -1; ovr_first = -1; to_first = -1;
        addr_ok = 1'b1;
        for (int t = 0; t < len; t++) begin
            sample_valid = (t == 0) || (t == sv2_at);
            adapt_en     = (t == 0) ? ae : 1'($urandom_range(0, 1));
            div_done     = (t == dd_at) || (t == dd2_at);
            clr_err      = 1'b0;
            @(negedge clk);
            if (adap_filter_state) begin
                if (f_first < 0) f_first = t;
                f_last = t;
            end
            if (div_state) begin
                if (d_first < 0) d_first = t;
                d_last = t;
                d_n++;
            end
            if (upd_en) begin
                if (u_first < 0) u_first = t;
                if (upd_addr != AW'(u_n)) addr_ok = 1'b0;
                u_n++;
            end
            if (frame_done && done_t < 0) done_t = t;
            if (err_overrun && ovr_first < 0) ovr_first = t;
            if (err_timeout && to_first < 0) to_first = t;
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        div_done     = 1'b0;
        cnt_end      = sample_cnt;
        rdy_end      = sample_ready;
    endtask

    task automatic check_full_frame(input string tag, input int exp_cnt);
        chk({tag, "_filt_first"}, f_first, 1);
        chk({tag, "_filt_last"}, f_last, 36);
        chk({tag, "_div_first"}, d_first, 38);
        chk({tag, "_div_last"}, d_last, 45);
        chk({tag, "_upd_first"}, u_first, 46);
        chk({tag, "_upd_count"}, u_n, 32);
        chk({tag, "_upd_addr_seq"}, int'(addr_ok), 1);
        chk({tag, "_frame_done_t"}, done_t, 78);
        chk({tag, "_sample_cnt"}, int'(cnt_end), exp_cnt);
        chk({tag, "_ready_t79"}, int'(rdy_end), 1);
    endtask

    initial begin
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Reset release followed by 10 idle cycles.
        repeat (10) @(posedge clk);
        #1;
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_filter", int'(adap_filter_state), 0);
        chk("rst_div", int'(div_state), 0);
        chk("rst_upd_en", int'(upd_en), 0);
        chk("rst_upd_addr", int'(upd_addr), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_sample_cnt", int'(sample_cnt), 0);
        chk("rst_errs", int'({err_overrun, err_timeout}), 0);

        // Full frame, divider answers at T = 45.
        frame(79, 1'b1, 45, -1, -1);
        check_full_frame("full", 1);

        // Filter-only frame.
        frame(40, 1'b0, -1, -1, -1);
        chk("fo_filt_last", f_last, 36);
        chk("fo_div_count", d_n, 0);
        chk("fo_upd_count", u_n, 0);
        chk("fo_frame_done_t", done_t, 38);

        // Divider never answers.
        frame(103, 1'b1, -1, -1, -1);
        chk("to_div_first", d_first, 38);
        chk("to_div_last", d_last, 100);
        chk("to_div_count", d_n, 63);
        chk("to_upd_count", u_n, 0);
        chk("to_frame_done_t", done_t, 101);
        chk("to_flag_first", to_first, 101);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        chk("to_flag_cleared", int'(err_timeout), 0);

        // Overrun during FILTER and a stray early div_done.
        frame(79, 1'b1, 45, 20, 10);
        check_full_frame("ovr", 4);
        chk("ovr_flag_first", ovr_first, 21);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        chk("ovr_flag_cleared", int'(err_overrun), 0);

        // Counter wrap from 0xFFFF.
        force dut.r_sample_cnt = 16'hFFFF;
        preload_req++;
        #1 release dut.r_sample_cnt;
        frame(40, 1'b0, -1, -1, -1);
        chk("wrap_frame_done_t", done_t, 38);
        chk("wrap_sample_cnt", int'(cnt_end), 0);

        // Asynchronous reset in the middle of UPDATE at upd_addr = 10.
        for (int t = 0; t < 56; t++) begin
            sample_valid = (t == 0);
            adapt_en     = 1'b1;
            div_done     = (t == 45);
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        div_done     = 1'b0;
        chk("mid_upd_addr", int'(upd_addr), 10);
        chk("mid_upd_en", int'(upd_en), 1);
        #1 rstn = 1'b0;
        #1;
        chk("arst_upd_en", int'(upd_en), 0);
        chk("arst_upd_addr", int'(upd_addr), 0);
        chk("arst_ready", int'(sample_ready), 1);
        chk("arst_sample_cnt", int'(sample_cnt), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        frame(79, 1'b1, 45, -1, -1);
        check_full_frame("post_rst", 1);

        // Randomized traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            rstn         = !(i == 2345);
            sample_valid = ($urandom_range(0, 15) == 0);
            adapt_en     = 1'($urandom_range(0, 1));
            if (i < 2000)
                div_done = ($urandom_range(0, 11) == 0);
            else
                div_done = ($urandom_range(0, 89) == 0);
            clr_err      = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        rstn         = 1'b1;
        sample_valid = 1'b0;
        div_done     = 1'b0;
        clr_err      = 1'b0;
        repeat (150) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nlms_frame_sequencer.md
Name: nlms_frame_sequencer

Overview:
- Sequences one adaptation frame of the 32-tap adaptive filter datapath, per input sample.
- Drives the filter accumulate enable (adap_filter_state), which accumulates w·ref and ref². Then holds one cycle so the error register latches. Then runs the normaliser/divider (div_state) and streams a tap-by-tap weight-update strobe.
- Sits between the sample source (ADC buffer) and the filter/divider/weight-bank blocks.
- Reports frame completion, overrun and divider timeout.

Parameters:
- TAPS, 32, number of weight taps updated per frame.
- FILT_CYCLES, 36, cycles adap_filter_state is held high; covers the 34-step MAC sweep plus 2 pipeline cycles.
- DIV_TIMEOUT, 63, maximum cycles spent in DIV waiting for div_done.
- ADDR_W, 6, width of upd_addr; must satisfy 2^ADDR_W >= TAPS.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-cycle pulse: new sample present in buffer_in_32.
- adapt_en  input  1  1 = full NLMS frame; 0 = filter-only frame (no DIV/UPDATE).
- div_done  input  1  divider result valid pulse.
- clr_err  input  1  synchronous clear of the sticky error flags.
- sample_ready  output  1  high only in IDLE.
- adap_filter_state  output  1  filter accumulate enable.
- div_state  output  1  divider run enable.
- upd_en  output  1  weight-write strobe, one tap per cycle.
- upd_addr  output  ADDR_W  tap index for upd_en.
- frame_done  output  1  one-cycle pulse at end of frame.
- sample_cnt  output  16  completed-frame count, wraps.
- err_overrun  output  1  sticky: sample_valid arrived outside IDLE.
- err_timeout  output  1  sticky: divider did not answer within DIV_TIMEOUT.

Behaviour:
- Moore FSM. All outputs are registered or decoded from the state register; no input-to-output combinational path.
- States: IDLE, FILTER, LATCH, DIV, UPDATE, DONE.
- Reset values: state = IDLE, sample_ready = 1, sample_cnt = 0, upd_addr = 0. All other outputs are 0.
- Internal counter cnt (ADDR_W+1 bits) is cleared on every state entry.
- IDLE:
  - sample_valid = 1 accepts the sample: adapt_en is captured into adapt_q, next state FILTER.
  - Otherwise stay in IDLE.
- FILTER:
  - adap_filter_state = 1.
  - Stay exactly FILT_CYCLES cycles, then go to LATCH.
- LATCH:
  - 1 cycle, adap_filter_state = 0; the filter's error register captures buffer_in_32 − d here.
  - Next state is DIV if adapt_q = 1, else DONE.
- DIV:
  - div_state = 1.
  - div_done = 1 seen in DIV cycle k: UPDATE from k+1.
  - If DIV_TIMEOUT cycles elapse with no div_done: set err_timeout, go to DONE, skip UPDATE.
- UPDATE:
  - upd_en = 1 for exactly TAPS cycles; upd_addr = 0, 1, …, TAPS−1, one per cycle.
  - Next state DONE.
  - upd_addr returns to 0 when leaving UPDATE.
- DONE:
  - frame_done = 1 for 1 cycle; sample_cnt increments, wrapping 0xFFFF → 0x0000.
  - Next state IDLE.
- sample_valid while not in IDLE:
  - The sample is dropped; err_overrun is set and the FSM is unaffected.
  - A sample_valid in the DONE cycle is also an overrun.
- div_done outside DIV is ignored.
- clr_err clears both error flags. If a set and clr_err occur in the same cycle, set wins.
- The error flags do not block operation.
- rstn assertion mid-frame forces IDLE and all reset values immediately (asynchronously). No partial update strobes are emitted after reset.
- Full-frame latency: accept at T, FILTER T+1..T+FILT_CYCLES, LATCH T+FILT_CYCLES+1.
- Filter-only frame: DONE at T+FILT_CYCLES+2.

Test Plan:
- Reset release, idle 10 cycles -> sample_ready = 1, all strobes 0, sample_cnt = 0.
- Defaults; sample_valid at T = 0, adapt_en = 1; div_done at T = 45 -> adap_filter_state high T = 1..36; LATCH T = 37; div_state high T = 38..45; upd_en high T = 46..77 with upd_addr 0..31; frame_done at T = 78; sample_cnt = 1; sample_ready at T = 79.
- adapt_en = 0, sample_valid at T = 0 -> div_state and upd_en never assert; frame_done at T = 38.
- div_done never asserted -> div_state high exactly 63 cycles (T = 38..100); err_timeout = 1 from T = 101; no upd_en; frame_done at T = 101. Then clr_err pulse -> err_timeout = 0.
- Overrun and stray div_done: sample_valid at T = 20 during FILTER, and div_done at T = 10 -> err_overrun = 1 from T = 21; frame timing identical to scenario 2; the early div_done has no effect.
- Wrap and reset: preload 65535 frames (or force sample_cnt = 0xFFFF) and run one frame -> sample_cnt = 0x0000. Separately, rstn low at upd_addr = 10 -> upd_en = 0 and state IDLE immediately; the next frame starts cleanly.
